// File: rtl/ps2_digit_receiver_pkg.sv
// Shared types, scan-code constants and digit decode for the PS/2 digit receiver.
// KEYPAD_DIGITS_EN: when defined, numeric-keypad make codes also decode as digits.
package ps2_digit_receiver_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Digit n lives in bits [n*8 +: 8]
  localparam logic [79:0] SC_DIGITS = {8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
                                       8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
`ifdef KEYPAD_DIGITS_EN
  localparam logic [79:0] SC_KEYPAD = {8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73,
                                       8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70};
`endif

  // Returns {hit, digit}
  function automatic logic [4:0] scan_to_digit(input logic [7:0] code);
    logic [4:0] result;
    result = '0;
    for (int i = 0; i < 10; i++) begin
      if (code == SC_DIGITS[i*8 +: 8]) result = {1'b1, 4'(i)};
`ifdef KEYPAD_DIGITS_EN
      if (code == SC_KEYPAD[i*8 +: 8]) result = {1'b1, 4'(i)};
`endif
    end
    return result;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserializer: input synchronizers, falling-edge detect, frame FSM, timeout.
// code_ok/code_err are strobes in the stop-edge (or timeout) cycle; the top registers them.
module ps2_frame_rx
  import ps2_digit_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_ok,
  output logic       code_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  rx_state_t              state;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg;
  logic                   parity;
  logic [TW-1:0]          to_cnt;

  logic fall;
  logic bit_in;
  logic timeout;
  logic frame_good;

  always_comb begin
    fall       = clk_prev & ~clk_sync[SYNC_STAGES-1];
    bit_in     = data_sync[SYNC_STAGES-1];
    timeout    = (state != IDLE) && !fall && (to_cnt == TO_LAST);
    frame_good = bit_in && ((^shreg) ^ parity);
    code       = shreg;
    code_ok    = fall && (state == STOP) && frame_good;
    code_err   = (fall && (state == IDLE) && bit_in) ||
                 (fall && (state == STOP) && !frame_good) ||
                 timeout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      parity    <= 1'b0;
      to_cnt    <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];

      // Saturating idle counter; only an edge clears it
      if (fall)
        to_cnt <= '0;
      else if (state != IDLE && to_cnt != TO_LAST)
        to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity <= bit_in;
            state  <= STOP;
          end
          STOP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_digit_receiver.sv
// PS/2 digit receiver top: break-code tracking, digit decode and registered output pulses.
// KEYPAD_DIGITS_EN: when defined, keypad make codes are accepted as digits too.
module ps2_digit_receiver
  import ps2_digit_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_digit,
  output logic       key_valid,
  output logic       frame_err,
  output logic       release_seen
);

  logic [7:0] code;
  logic       code_ok;
  logic       code_err;
  logic [4:0] decoded;
  logic       break_flag;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_frame_rx (
    .clk     (clk),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .code    (code),
    .code_ok (code_ok),
    .code_err(code_err)
  );

  assign decoded = scan_to_digit(code);

  always_ff @(posedge clk) begin
    if (reset) begin
      key_digit    <= '0;
      key_valid    <= 1'b0;
      frame_err    <= 1'b0;
      release_seen <= 1'b0;
      break_flag   <= 1'b0;
    end else begin
      key_valid    <= 1'b0;
      frame_err    <= 1'b0;
      release_seen <= 1'b0;
      if (code_err) begin
        frame_err  <= 1'b1;
        break_flag <= 1'b0;
      end else if (code_ok) begin
        if (code == SC_BREAK) begin
          break_flag <= 1'b1;
        end else if (code != SC_EXT) begin
          // The code after F0 ends the break sequence whatever it is
          if (break_flag) begin
            break_flag   <= 1'b0;
            release_seen <= decoded[4];
          end else if (decoded[4]) begin
            key_digit <= decoded[3:0];
            key_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_digit_receiver.sv
// Self-checking bench for ps2_digit_receiver: table-driven frames plus hand-written corner cases.
// Expected pulses are queued before each frame and popped by a monitor; honours KEYPAD_DIGITS_EN.
module tb_ps2_digit_receiver;

  localparam int TB_TIMEOUT = 400;
  localparam int HALF       = 6;
  localparam int LAT        = 3;  // two sync stages plus the output register

  localparam logic [2:0] P_NONE  = 3'b000;
  localparam logic [2:0] P_VALID = 3'b100;
  localparam logic [2:0] P_ERR   = 3'b010;
  localparam logic [2:0] P_REL   = 3'b001;

  typedef struct {
    logic [2:0] pulses;
    logic [3:0] digit;
  } exp_t;

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       stop;
    logic [2:0] pulses;
    logic [3:0] digit;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] key_digit;
  logic       key_valid;
  logic       frame_err;
  logic       release_seen;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_fall_cycle = 0;
  int   stop_fall_cycle = 0;
  int   last_valid_cycle = 0;
  int   last_err_cycle = 0;
  exp_t sb[$];
  vec_t vecs[19];

  ps2_digit_receiver #(
    .TIMEOUT_CYCLES(TB_TIMEOUT),
    .SYNC_STAGES   (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_digit   (key_digit),
    .key_valid   (key_valid),
    .frame_err   (frame_err),
    .release_seen(release_seen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [2:0] p, input logic [3:0] d);
    exp_t e;
    e.pulses = p;
    e.digit  = d;
    sb.push_back(e);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset && (key_valid || frame_err || release_seen)) begin
        exp_t e;
        logic [2:0] got;
        got = {key_valid, frame_err, release_seen};
        if (key_valid) last_valid_cycle = cyc;
        if (frame_err) last_err_cycle = cyc;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got pulses=%b digit=%0d, required no pulse", got, key_digit);
        end else begin
          e = sb.pop_front();
          if (got !== e.pulses || key_digit !== e.digit) begin
            errors++;
            $display("FAIL pulse_event: got pulses=%b digit=%0d, required pulses=%b digit=%0d",
                     got, key_digit, e.pulses, e.digit);
          end else begin
            $display("event pulses=%b digit=%0d at cycle %0d", got, key_digit, cyc);
          end
        end
      end
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall_cycle = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(~(^code) ^ bad_par);
    send_bit(stop);
    stop_fall_cycle = last_fall_cycle;
  endtask

  task automatic drain(input string name, input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pulse(s) missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vecs[0]  = '{8'hF0, 1'b0, 1'b1, P_NONE,  4'd1};
    vecs[1]  = '{8'h16, 1'b0, 1'b1, P_REL,   4'd1};
    vecs[2]  = '{8'h45, 1'b0, 1'b1, P_VALID, 4'd0};
    vecs[3]  = '{8'h45, 1'b1, 1'b1, P_ERR,   4'd0};
    vecs[4]  = '{8'h1E, 1'b0, 1'b1, P_VALID, 4'd2};
    vecs[5]  = '{8'h26, 1'b0, 1'b0, P_ERR,   4'd2};
    vecs[6]  = '{8'h1C, 1'b0, 1'b1, P_NONE,  4'd2};
`ifdef KEYPAD_DIGITS_EN
    vecs[7]  = '{8'h70, 1'b0, 1'b1, P_VALID, 4'd0};
`else
    vecs[7]  = '{8'h70, 1'b0, 1'b1, P_NONE,  4'd2};
`endif
    vecs[8]  = '{8'h3D, 1'b0, 1'b1, P_VALID, 4'd7};
    vecs[9]  = '{8'hF0, 1'b0, 1'b1, P_NONE,  4'd7};
    vecs[10] = '{8'h1C, 1'b0, 1'b1, P_NONE,  4'd7};
    vecs[11] = '{8'h2E, 1'b0, 1'b1, P_VALID, 4'd5};
    vecs[12] = '{8'hF0, 1'b0, 1'b1, P_NONE,  4'd5};
    vecs[13] = '{8'h3E, 1'b1, 1'b1, P_ERR,   4'd5};
    vecs[14] = '{8'h36, 1'b0, 1'b1, P_VALID, 4'd6};
    vecs[15] = '{8'hE0, 1'b0, 1'b1, P_NONE,  4'd6};
    vecs[16] = '{8'hF0, 1'b0, 1'b1, P_NONE,  4'd6};
    vecs[17] = '{8'h3E, 1'b0, 1'b1, P_REL,   4'd6};
    vecs[18] = '{8'h3E, 1'b0, 1'b1, P_VALID, 4'd8};

    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({key_digit, key_valid, frame_err, release_seen} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: got digit=%0d v=%b e=%b r=%b, required all 0",
               key_digit, key_valid, frame_err, release_seen);
    end
    reset = 1'b0;
    fork monitor(); join_none

    // First make code: check latency from the stop edge
    push(P_VALID, 4'd1);
    send_frame(8'h16, 1'b0, 1'b1);
    drain("make_16", 50);
    checks++;
    if (last_valid_cycle - stop_fall_cycle != LAT) begin
      errors++;
      $display("FAIL valid_latency: got %0d cycles, required %0d",
               last_valid_cycle - stop_fall_cycle, LAT);
    end
    $display("txn make 16 done");

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].pulses != P_NONE) push(vecs[i].pulses, vecs[i].digit);
      send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].stop);
      if (vecs[i].pulses != P_NONE) drain($sformatf("vec%0d", i), 50);
      else repeat (20) @(negedge clk);
      $display("txn vec %0d code=%h bad_par=%b stop=%b", i, vecs[i].code, vecs[i].bad_par, vecs[i].stop);
    end

    // Start bit of 1 is rejected straight from IDLE
    push(P_ERR, 4'd8);
    send_bit(1'b1);
    drain("bad_start", 50);
    $display("txn bad start bit");

    // Partial frame abandoned by the timeout
    push(P_ERR, 4'd8);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    drain("timeout", TB_TIMEOUT + 100);
    checks++;
    if (last_err_cycle - last_fall_cycle != TB_TIMEOUT + LAT) begin
      errors++;
      $display("FAIL timeout_cycle: got %0d cycles after last edge, required %0d",
               last_err_cycle - last_fall_cycle, TB_TIMEOUT + LAT);
    end
    $display("txn timeout");

    push(P_VALID, 4'd9);
    send_frame(8'h46, 1'b0, 1'b1);
    drain("after_timeout_46", 50);
    $display("txn make 46 after timeout");

    // Reset after the 5th data edge of 0x26 (data LSB-first 0,1,1,0,0)
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({key_digit, key_valid, frame_err, release_seen} !== 7'd0) begin
      errors++;
      $display("FAIL post_reset: got digit=%0d v=%b e=%b r=%b, required all 0",
               key_digit, key_valid, frame_err, release_seen);
    end
    push(P_VALID, 4'd3);
    send_frame(8'h26, 1'b0, 1'b1);
    drain("reset_then_26", 50);
    $display("txn reset mid-frame then make 26");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_digit_receiver.md
Name: ps2_digit_receiver

Overview:
Input-side counterpart of the 4-digit seven-segment display path. Deserializes PS/2 keyboard frames (11-bit: start, 8 data LSB-first, odd parity, stop) and decodes make codes for digit keys 0-9 into a 4-bit value. Releases, non-digit keys and malformed frames do not produce a digit. Output feeds the game logic that compares the typed digit against random_num and updates score.

Parameters:
TIMEOUT_CYCLES, 20000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned
SYNC_STAGES, 2, flip-flop depth of the ps2_clk/ps2_data synchronizers (minimum 2)

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk
ps2_data  input  1  raw PS/2 data, asynchronous to clk
key_digit  output  4  decoded digit 0-9; holds the last valid value
key_valid  output  1  one-cycle pulse: key_digit was just updated by a digit make code
frame_err  output  1  one-cycle pulse: bad start, parity or stop bit, or timeout mid-frame
release_seen  output  1  one-cycle pulse: a digit break sequence (F0 then digit code) completed

Behaviour:
- Reset: key_digit=0, key_valid=0, frame_err=0, release_seen=0, FSM=IDLE, break flag cleared, bit counter=0, timeout counter=0, synchronizers loaded with 1.
- Both inputs pass through SYNC_STAGES flops. A falling edge is detected when the previous synced ps2_clk is 1 and the current one is 0. Each bit is sampled from synced ps2_data in that edge cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge, data=0 -> DATA with bitcnt=0. data=1 -> frame_err pulse, stay IDLE.
  - DATA: on each edge, shift data into shreg[7] (right shift). After 8 bits -> PARITY.
  - PARITY: on an edge, store the bit -> STOP.
  - STOP: on an edge, the frame is good iff stop=1 and XOR(shreg, parity)=1. Return to IDLE either way.
- Frame accepted (cycle after the stop edge, latency 1):
  - code F0: set break flag; no other output.
  - break flag set: clear it. If the code is a digit, pulse release_seen. Never pulse key_valid.
  - digit make code: key_digit <= decoded value; key_valid pulses for exactly one cycle.
  - E0 or any other code: ignored; break flag unchanged.
- Bad frame: frame_err pulses in the cycle after the stop edge, break flag cleared, no key_valid.
- Timeout: the counter resets on every edge and counts only while the FSM is not IDLE. When it reaches TIMEOUT_CYCLES-1: FSM -> IDLE, frame_err pulses, break flag cleared. Saturates; never wraps.
- Digit make codes: 0=45 1=16 2=1E 3=26 4=25 5=2E 6=36 7=3D 8=3E 9=46 (hex).
- key_valid, frame_err and release_seen are mutually exclusive in any cycle.
- Reset asserted mid-frame discards the partial frame; no pulse appears in the cycle after reset deasserts.

Optional Feature:
- Macro KEYPAD_DIGITS_EN.
- Defined: numeric keypad make codes also decode: 0=70 1=69 2=72 3=7A 4=6B 5=73 6=74 7=6C 8=75 9=7D (hex). They follow the same break rules.
- Undefined: these codes are treated as non-digit and ignored.

Decomposition:
- Shared package: FSM state enum, scan-code localparams (F0, E0, the digit codes), and a function scan_to_digit returning {hit, digit[3:0]}.
- Natural sub-module: ps2_frame_rx. It contains the synchronizer, edge detect, FSM and timeout, and outputs {code[7:0], code_ok, code_err}. The top level holds the break flag, digit decode and output registers.

Test Plan:
- Frame for 0x16 (parity 0, stop 1) -> one key_valid pulse, key_digit=1, one cycle after the stop edge. frame_err=0.
- Frames F0 then 0x16 -> no key_valid; release_seen pulses once; key_digit keeps its prior value.
- Frame 0x45 with wrong parity -> frame_err pulse; no key_valid; key_digit unchanged.
- 4 bits of a frame, then idle TIMEOUT_CYCLES -> frame_err pulse at the timeout. A following good 0x46 frame gives key_valid with key_digit=9.
- Frame 0x1C (letter A) -> no pulse on any output. Frame 0x70 -> key_valid with key_digit=0 only when KEYPAD_DIGITS_EN is defined; no pulse when it is undefined.
- reset asserted after the 5th data edge of a 0x26 frame, then a full 0x26 frame -> exactly one key_valid pulse with key_digit=3.
